// File: rtl/sipo_deserializer.sv
// Serial-to-parallel deserializer: rebuilds WIDTH-bit words from a strobed bit stream, valid/ready output.
// Optional even-parity trailer bit enabled by defining SIPO_PARITY_EN.
module sipo_deserializer #(
  parameter int WIDTH   = 32,
  parameter int GAP_MAX = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sdata,
  input  logic             svalid,
  input  logic             dir,
  output logic [WIDTH-1:0] pdata,
  output logic             pvalid,
  input  logic             pready,
  output logic             busy,
  output logic             overrun,
  output logic             frame_err,
  output logic             parity_err
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int GW = (GAP_MAX > 0) ? $clog2(GAP_MAX + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP_MAX > 0) ? GAP_MAX - 1 : 0);
  localparam logic [GW-1:0] GAP_ONE  = GW'(1);

`ifdef SIPO_PARITY_EN
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, PAR = 2'd2} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1} state_t;
`endif

  state_t           state, state_nxt;
  logic [WIDTH-1:0] shreg, shreg_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic [GW-1:0]    gap, gap_nxt;
  logic             dir_q, dir_q_nxt;
  logic [WIDTH-1:0] pdata_nxt;
  logic             pvalid_nxt, busy_nxt;
  logic             overrun_nxt, frame_err_nxt, parity_err_nxt;
  logic             word_done;
  logic [WIDTH-1:0] word;

  function automatic logic [WIDTH-1:0] place_bit(input logic [WIDTH-1:0] w,
                                                 input logic b,
                                                 input logic [CW-1:0] pos);
    return w | ({{(WIDTH-1){1'b0}}, b} << pos);
  endfunction

`ifdef SIPO_PARITY_EN
  function automatic logic even_par(input logic [WIDTH-1:0] w);
    return ^w;
  endfunction
`endif

  // Next-state, datapath and output computation
  always_comb begin
    state_nxt      = state;
    shreg_nxt      = shreg;
    cnt_nxt        = cnt;
    gap_nxt        = gap;
    dir_q_nxt      = dir_q;
    pdata_nxt      = pdata;
    overrun_nxt    = 1'b0;
    frame_err_nxt  = 1'b0;
    parity_err_nxt = 1'b0;
    word_done      = 1'b0;
    word           = shreg;

    if (pvalid && pready) begin
      pvalid_nxt = 1'b0;
    end else begin
      pvalid_nxt = pvalid;
    end

    case (state)
      IDLE: begin
        gap_nxt = '0;
        if (svalid) begin
          dir_q_nxt = dir;
          shreg_nxt = place_bit('0, sdata, dir ? CNT_LAST : '0);
          cnt_nxt   = CNT_ONE;
          state_nxt = SHIFT;
        end else begin
          state_nxt = IDLE;
        end
      end

      SHIFT: begin
        if (svalid) begin
          gap_nxt   = '0;
          shreg_nxt = place_bit(shreg, sdata, dir_q ? (CNT_LAST - cnt) : cnt);
          if (cnt == CNT_LAST) begin
            cnt_nxt = '0;
`ifdef SIPO_PARITY_EN
            state_nxt = PAR;
`else
            word_done = 1'b1;
            word      = shreg_nxt;
            state_nxt = IDLE;
`endif
          end else begin
            cnt_nxt = cnt + CNT_ONE;
          end
        end else if ((GAP_MAX != 0) && (gap == GAP_LAST)) begin
          frame_err_nxt = 1'b1;
          cnt_nxt       = '0;
          gap_nxt       = '0;
          state_nxt     = IDLE;
        end else if (GAP_MAX != 0) begin
          gap_nxt = gap + GAP_ONE;
        end else begin
          gap_nxt = gap;
        end
      end

`ifdef SIPO_PARITY_EN
      // The completed word waits in shreg for its trailing parity bit
      PAR: begin
        if (svalid) begin
          gap_nxt   = '0;
          state_nxt = IDLE;
          if (even_par(shreg) ^ sdata) begin
            parity_err_nxt = 1'b1;
          end else begin
            word_done = 1'b1;
            word      = shreg;
          end
        end else if ((GAP_MAX != 0) && (gap == GAP_LAST)) begin
          frame_err_nxt = 1'b1;
          cnt_nxt       = '0;
          gap_nxt       = '0;
          state_nxt     = IDLE;
        end else if (GAP_MAX != 0) begin
          gap_nxt = gap + GAP_ONE;
        end else begin
          gap_nxt = gap;
        end
      end
`endif

      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
        gap_nxt   = '0;
      end
    endcase

    // A consumer taking the held word this edge frees the register for the new one
    if (word_done) begin
      if (!pvalid || pready) begin
        pdata_nxt  = word;
        pvalid_nxt = 1'b1;
      end else begin
        overrun_nxt = 1'b1;
      end
    end else begin
      pdata_nxt = pdata;
    end

    busy_nxt = (state_nxt != IDLE);
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      shreg      <= '0;
      cnt        <= '0;
      gap        <= '0;
      dir_q      <= 1'b0;
      pdata      <= '0;
      pvalid     <= 1'b0;
      busy       <= 1'b0;
      overrun    <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      state      <= state_nxt;
      shreg      <= shreg_nxt;
      cnt        <= cnt_nxt;
      gap        <= gap_nxt;
      dir_q      <= dir_q_nxt;
      pdata      <= pdata_nxt;
      pvalid     <= pvalid_nxt;
      busy       <= busy_nxt;
      overrun    <= overrun_nxt;
      frame_err  <= frame_err_nxt;
      parity_err <= parity_err_nxt;
    end
  end

endmodule

// File: tb/tb_sipo_deserializer.sv
// Scoreboard bench for sipo_deserializer (WIDTH=8, GAP_MAX=4); parity cases run when SIPO_PARITY_EN is defined.
module tb_sipo_deserializer;
  logic       clk = 1'b0;
  logic       rst, sdata, svalid, dir, pready;
  logic [7:0] pdata;
  logic       pvalid, busy, overrun, frame_err, parity_err;

  int errors = 0;
  int checks = 0;
  int ov_seen = 0, fe_seen = 0, pe_seen = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  sipo_deserializer #(.WIDTH(8), .GAP_MAX(4)) dut (
    .clk(clk), .rst(rst), .sdata(sdata), .svalid(svalid), .dir(dir),
    .pdata(pdata), .pvalid(pvalid), .pready(pready), .busy(busy),
    .overrun(overrun), .frame_err(frame_err), .parity_err(parity_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // bits[7] goes out first; dir is flipped after the first bit to show it is ignored mid-word
  task automatic send_bits(input logic [7:0] bits, input logic d, input logic p);
    for (int i = 7; i >= 0; i--) begin
      sdata  = bits[i];
      svalid = 1'b1;
      dir    = (i == 7) ? d : ~d;
      tick();
    end
`ifdef SIPO_PARITY_EN
    sdata  = p;
    svalid = 1'b1;
    tick();
`else
    sdata = p;
`endif
    svalid = 1'b0;
    sdata  = 1'b0;
  endtask

  // Monitor: pops the scoreboard on every accepted word and counts error pulses
  always @(negedge clk) begin
    if (rst) begin
      if (overrun)    ov_seen++;
      if (frame_err)  fe_seen++;
      if (parity_err) pe_seen++;
      if (pvalid && pready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word: got %0h expected none", pdata);
        end else begin
          check("word", {24'h0, pdata}, {24'h0, exp_q.pop_front()});
        end
      end
    end
  end

  initial begin
    rst = 1'b0; sdata = 1'b0; svalid = 1'b0; dir = 1'b0; pready = 1'b0;
    #12;
    check("rst_pdata", {24'h0, pdata}, 32'h0);
    check("rst_pvalid", pvalid, 32'h0);
    check("rst_busy", busy, 32'h0);
    check("rst_overrun", overrun, 32'h0);
    check("rst_frame_err", frame_err, 32'h0);
    check("rst_parity_err", parity_err, 32'h0);
    @(negedge clk) rst = 1'b1;
    tick();

    // MSB-first A5, then LSB-first A5 and 03 back-to-back
    pready = 1'b1;
    exp_q.push_back(8'hA5);
    send_bits(8'b10100101, 1'b1, 1'b0);
    check("a5_pvalid", pvalid, 32'h1);
    check("a5_busy", busy, 32'h0);
    tick();
    check("a5_pvalid_clear", pvalid, 32'h0);
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h03);
    send_bits(8'b10100101, 1'b0, 1'b0);
    send_bits(8'b11000000, 1'b0, 1'b0);
    tick();
    tick();

    // Overrun: 22 is dropped while 11 is still held
    pready = 1'b0;
    exp_q.push_back(8'h11);
    send_bits(8'b00010001, 1'b1, 1'b0);
    send_bits(8'b00100010, 1'b1, 1'b0);
    check("ovr_pulse", overrun, 32'h1);
    check("ovr_pdata", {24'h0, pdata}, 32'h11);
    check("ovr_pvalid", pvalid, 32'h1);
    tick();
    check("ovr_pulse_end", overrun, 32'h0);
    check("ovr_pdata_hold", {24'h0, pdata}, 32'h11);
    pready = 1'b1;
    tick();
    check("ovr_pvalid_clear", pvalid, 32'h0);

    // Gap timeout after three bits
    sdata = 1'b1; svalid = 1'b1; dir = 1'b1;
    repeat (3) tick();
    svalid = 1'b0;
    check("gap_busy_start", busy, 32'h1);
    repeat (3) tick();
    check("gap_no_err_yet", frame_err, 32'h0);
    check("gap_busy_mid", busy, 32'h1);
    tick();
    check("gap_frame_err", frame_err, 32'h1);
    check("gap_busy_end", busy, 32'h0);
    check("gap_pvalid", pvalid, 32'h0);
    tick();
    check("gap_frame_err_end", frame_err, 32'h0);
    exp_q.push_back(8'h5A);
    send_bits(8'b01011010, 1'b1, 1'b0);
    repeat (2) tick();

    // Reset mid-word (cnt=5) while a word is held
    pready = 1'b0;
    send_bits(8'b00111100, 1'b1, 1'b0);
    check("rmid_pvalid_before", pvalid, 32'h1);
    for (int i = 0; i < 5; i++) begin
      sdata = (i < 2) ? 1'b1 : 1'b0;
      svalid = 1'b1;
      tick();
    end
    check("rmid_busy_before", busy, 32'h1);
    rst = 1'b0;
    #1;
    check("rmid_pdata", {24'h0, pdata}, 32'h0);
    check("rmid_pvalid", pvalid, 32'h0);
    check("rmid_busy", busy, 32'h0);
    check("rmid_flags", {29'h0, overrun, frame_err, parity_err}, 32'h0);
    svalid = 1'b0; sdata = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    tick();
    pready = 1'b1;
    exp_q.push_back(8'hC3);
    send_bits(8'b11000011, 1'b1, 1'b0);
    repeat (2) tick();

`ifdef SIPO_PARITY_EN
    exp_q.push_back(8'h07);
    send_bits(8'b00000111, 1'b1, 1'b1);
    repeat (2) tick();
    send_bits(8'b00000111, 1'b1, 1'b0);
    check("par_err_pulse", parity_err, 32'h1);
    check("par_pvalid", pvalid, 32'h0);
    tick();
    check("par_err_end", parity_err, 32'h0);
`endif

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
    check("queue_drained", exp_q.size(), 32'h0);
    check("overrun_pulses", ov_seen, 32'h1);
    check("frame_err_pulses", fe_seen, 32'h1);
`ifdef SIPO_PARITY_EN
    check("parity_err_pulses", pe_seen, 32'h1);
`else
    check("parity_err_pulses", pe_seen, 32'h0);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
